// File: rtl/store_outstanding_ctrl.sv
// Store-issue throttle between the dcache write buffer and AXI AW/B: caps outstanding writes,
// drains on fence and captures bus errors. Optional per-ID tracking: STORE_OUTSTANDING_ID_CHECK_EN.
module store_outstanding_ctrl #(
  parameter int unsigned MaxOutstanding = 7,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                st_valid_i,
  input  logic [IdWidth-1:0]  st_id_i,
  output logic                st_ready_o,
  output logic                aw_valid_o,
  input  logic                aw_ready_i,
  input  logic                b_valid_i,
  input  logic [IdWidth-1:0]  b_id_i,
  input  logic [1:0]          b_resp_i,
  output logic                b_ready_o,
  input  logic                fence_i,
  output logic                fence_done_o,
  output logic [CntWidth-1:0] outstanding_cnt_o,
  output logic                bus_err_o,
  output logic [IdWidth-1:0]  bus_err_id_o,
  input  logic                bus_err_clr_i,
  output logic                unexpected_b_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 bus_err_q, bus_err_d;
  logic [IdWidth-1:0]   bus_err_id_q, bus_err_id_d;
  logic                 full, run, issue, resp_ok, err_ev;
  logic                 unused_resp0;

  // Gating uses the registered count only, so a same-cycle B never unblocks issue.
  assign full       = (cnt_q == MaxCnt);
  assign run        = (state_q == StRun);
  assign aw_valid_o = st_valid_i & ~full & run;
  assign st_ready_o = aw_ready_i & ~full & run;
  assign issue      = aw_valid_o & aw_ready_i;
  assign b_ready_o  = 1'b1;
  assign err_ev     = b_valid_i & b_resp_i[1];

  assign unused_resp0 = b_resp_i[0];

`ifdef STORE_OUTSTANDING_ID_CHECK_EN
  localparam int unsigned NumIds = 2 ** IdWidth;

  logic [CntWidth-1:0] id_cnt_q [NumIds];
  logic                id_hit;
  logic                unexp_q;

  assign id_hit         = (id_cnt_q[b_id_i] != '0);
  assign resp_ok        = b_valid_i & id_hit;
  assign unexpected_b_o = unexp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumIds; i++) id_cnt_q[i] <= '0;
      unexp_q <= 1'b0;
    end else begin
      for (int i = 0; i < NumIds; i++) begin
        if (issue && st_id_i == IdWidth'(i) && !(resp_ok && b_id_i == IdWidth'(i))) begin
          id_cnt_q[i] <= id_cnt_q[i] + CntWidth'(1);
        end else if (resp_ok && b_id_i == IdWidth'(i) && !(issue && st_id_i == IdWidth'(i))) begin
          id_cnt_q[i] <= id_cnt_q[i] - CntWidth'(1);
        end
      end
      unexp_q <= b_valid_i & ~id_hit;
    end
  end
`else
  logic unused_st_id;

  assign unused_st_id   = ^st_id_i;
  assign resp_ok        = b_valid_i;
  assign unexpected_b_o = 1'b0;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (issue && !resp_ok) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (!issue && resp_ok && cnt_q != '0) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (fence_i) state_d = (cnt_q == '0 && !issue) ? StDone : StDrain;
      end
      StDrain: begin
        if (cnt_q == '0) state_d = StDone;
      end
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // A new error in the same cycle as a clear is captured rather than dropped.
  always_comb begin
    bus_err_d    = bus_err_q;
    bus_err_id_d = bus_err_id_q;
    if (err_ev && (!bus_err_q || bus_err_clr_i)) begin
      bus_err_d    = 1'b1;
      bus_err_id_d = b_id_i;
    end else if (bus_err_clr_i) begin
      bus_err_d    = 1'b0;
      bus_err_id_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StRun;
      cnt_q        <= '0;
      bus_err_q    <= 1'b0;
      bus_err_id_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_err_q    <= bus_err_d;
      bus_err_id_q <= bus_err_id_d;
    end
  end

  assign fence_done_o      = (state_q == StDone);
  assign outstanding_cnt_o = cnt_q;
  assign bus_err_o         = bus_err_q;
  assign bus_err_id_o      = bus_err_id_q;

endmodule

// File: tb/tb_store_outstanding_ctrl.sv
// Scoreboard bench for store_outstanding_ctrl: directed scenarios plus random traffic against a
// queue/arithmetic reference model; a negedge monitor pops expected snapshots and compares.
module tb_store_outstanding_ctrl;

  localparam int Max = 7;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       st_valid_i = 1'b0;
  logic [3:0] st_id_i = '0;
  logic       st_ready_o;
  logic       aw_valid_o;
  logic       aw_ready_i = 1'b0;
  logic       b_valid_i = 1'b0;
  logic [3:0] b_id_i = '0;
  logic [1:0] b_resp_i = '0;
  logic       b_ready_o;
  logic       fence_i = 1'b0;
  logic       fence_done_o;
  logic [2:0] outstanding_cnt_o;
  logic       bus_err_o;
  logic [3:0] bus_err_id_o;
  logic       bus_err_clr_i = 1'b0;
  logic       unexpected_b_o;

  store_outstanding_ctrl #(
    .MaxOutstanding(7),
    .IdWidth       (4)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .st_valid_i       (st_valid_i),
    .st_id_i          (st_id_i),
    .st_ready_o       (st_ready_o),
    .aw_valid_o       (aw_valid_o),
    .aw_ready_i       (aw_ready_i),
    .b_valid_i        (b_valid_i),
    .b_id_i           (b_id_i),
    .b_resp_i         (b_resp_i),
    .b_ready_o        (b_ready_o),
    .fence_i          (fence_i),
    .fence_done_o     (fence_done_o),
    .outstanding_cnt_o(outstanding_cnt_o),
    .bus_err_o        (bus_err_o),
    .bus_err_id_o     (bus_err_id_o),
    .bus_err_clr_i    (bus_err_clr_i),
    .unexpected_b_o   (unexpected_b_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit aw_valid;
    bit st_ready;
    bit fence_done;
    bit bus_err;
    bit unexp;
    int cnt;
    int err_id;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Reference model: outstanding total, per-ID totals, fence progress flags, error record.
  int m_cnt;
  int m_idcnt[16];
  bit m_drain;
  bit m_done;
  bit m_err;
  int m_err_id;
  bit m_unexp;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_drain = 0; m_done = 0; m_err = 0; m_err_id = 0; m_unexp = 0;
    foreach (m_idcnt[i]) m_idcnt[i] = 0;
  endtask

  task automatic cycle(input bit rst, input bit sv, input int sid, input bit awr, input bit bv,
                       input int bid, input int bresp, input bit fence, input bit clr);
    exp_t e;
    bit   blocked, issue, resp, done_n, drain_n;
    int   n;
    @(posedge clk);
    #1;
    rst_ni = rst; st_valid_i = sv; st_id_i = sid[3:0]; aw_ready_i = awr; b_valid_i = bv;
    b_id_i = bid[3:0]; b_resp_i = bresp[1:0]; fence_i = fence; bus_err_clr_i = clr;
    if (!rst) model_reset();
    blocked    = m_drain || m_done || (m_cnt == Max);
    e.aw_valid = sv && !blocked;
    e.st_ready = awr && !blocked;
    e.cnt = m_cnt; e.fence_done = m_done; e.bus_err = m_err; e.err_id = m_err_id;
    e.unexp = m_unexp;
    exp_q.push_back(e);
    if (rst) begin
      issue = e.aw_valid && awr;
`ifdef STORE_OUTSTANDING_ID_CHECK_EN
      resp    = bv && (m_idcnt[bid] > 0);
      m_unexp = bv && !resp;
      if (issue) m_idcnt[sid]++;
      if (resp) m_idcnt[bid]--;
`else
      resp    = bv;
      m_unexp = 0;
`endif
      n = m_cnt + int'(issue) - int'(resp);
      if (n < 0) n = 0;
      if (m_done) begin
        done_n = 0; drain_n = 0;
      end else if (m_drain) begin
        done_n = (m_cnt == 0); drain_n = (m_cnt != 0);
      end else if (fence) begin
        done_n = (m_cnt == 0) && !issue; drain_n = !done_n;
      end else begin
        done_n = 0; drain_n = 0;
      end
      if (bv && bresp[1] && (!m_err || clr)) begin
        m_err = 1; m_err_id = bid;
      end else if (clr) begin
        m_err = 0; m_err_id = 0;
      end
      m_cnt = n; m_done = done_n; m_drain = drain_n;
    end
  endtask

  task automatic idle(input int k);
    repeat (k) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("aw_valid", int'(aw_valid_o), int'(e.aw_valid));
        chk("st_ready", int'(st_ready_o), int'(e.st_ready));
        chk("outstanding_cnt", int'(outstanding_cnt_o), e.cnt);
        chk("fence_done", int'(fence_done_o), int'(e.fence_done));
        chk("bus_err", int'(bus_err_o), int'(e.bus_err));
        chk("bus_err_id", int'(bus_err_id_o), e.err_id);
        chk("unexpected_b", int'(unexpected_b_o), int'(e.unexp));
        chk("b_ready", int'(b_ready_o), 1);
      end
    end
  end

  initial begin : driver
    int bv_pct;
    model_reset();
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Fill to the limit, eighth store blocked, same-cycle B does not unblock.
    repeat (8) cycle(1, 1, 3, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 3, 1, 1, 3, 0, 0, 0);
    cycle(1, 1, 3, 1, 0, 0, 0, 0, 0);
    // Down to 3, then simultaneous issue and response.
    repeat (4) cycle(1, 0, 3, 1, 1, 3, 0, 0, 0);
    cycle(1, 1, 3, 1, 1, 3, 0, 0, 0);
    // cnt=2 fence with store requests held.
    cycle(1, 0, 3, 1, 1, 3, 0, 0, 0);
    cycle(1, 0, 3, 1, 0, 0, 0, 1, 0);
    repeat (2) cycle(1, 1, 3, 1, 1, 3, 0, 1, 0);
    repeat (4) cycle(1, 1, 3, 1, 0, 0, 0, 0, 0);
    // Drain past zero (saturation), then fence with nothing outstanding.
    repeat (8) cycle(1, 0, 3, 1, 1, 3, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0, 0, 1, 0);
    idle(3);
    // Bus errors: first ID sticks, clear, then clear racing a new error.
    cycle(1, 0, 0, 0, 1, 5, 2, 0, 0);
    cycle(1, 0, 0, 0, 1, 9, 3, 0, 0);
    idle(1);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    cycle(1, 0, 0, 0, 1, 7, 2, 0, 0);
    cycle(1, 0, 0, 0, 1, 9, 3, 0, 1);
    idle(1);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // ID mismatch handling.
    cycle(1, 1, 3, 1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 4, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 3, 0, 0, 0);
    idle(2);
    // Reset mid-drain.
    repeat (3) cycle(1, 1, 2, 1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // Random traffic; response rate alternates so the count sweeps its whole range.
    for (int i = 0; i < 3000; i++) begin
      bv_pct = ((i / 200) % 2 == 0) ? 20 : 65;
      cycle($urandom_range(0, 399) != 0,
            $urandom_range(0, 99) < 75,
            int'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < bv_pct,
            int'($urandom_range(0, 4)),
            int'($urandom_range(0, 3)),
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 29) == 0);
    end
    idle(2);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
